// File: rtl/lifo_stack.sv
// Data-holding LIFO stack with occupancy count, full/empty status and sticky error flags.
// Pop data is registered onto dout with a one-cycle dout_valid pulse.
module lifo_stack #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic [CNT_W-1:0]  cnt,
   output logic              empty,
   output logic              full,
   output logic              err_overflow,
   output logic              err_underflow
);

   typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

   localparam int                IDX_W   = CNT_W - 1;
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt_nxt, cnt_inc, cnt_dec;
   logic [IDX_W-1:0]   wr_idx, rd_idx, mem_waddr;
   logic               mem_we, dout_load, valid_nxt, ovf_set, udf_set;
   logic [DATA_W-1:0]  dout_nxt;
   logic [DATA_W-1:0]  mem [DEPTH];

   assign cnt_inc = cnt + CNT_ONE;
   assign cnt_dec = cnt - CNT_ONE;
   // Top-of-stack index is (cnt-1) truncated, which equals the low bits of cnt minus one.
   assign wr_idx  = cnt[IDX_W-1:0];
   assign rd_idx  = cnt[IDX_W-1:0] - IDX_ONE;

   assign empty = (state == S_EMPTY);
   assign full  = (state == S_FULL);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_nxt = state;
      cnt_nxt   = cnt;
      mem_we    = 1'b0;
      mem_waddr = wr_idx;
      dout_load = 1'b0;
      dout_nxt  = mem[rd_idx];
      valid_nxt = 1'b0;
      ovf_set   = 1'b0;
      udf_set   = 1'b0;
      unique case ({push, pop})
         2'b10: begin
            if (state != S_FULL) begin
               mem_we    = 1'b1;
               cnt_nxt   = cnt_inc;
               state_nxt = (cnt_inc == DEPTH_C) ? S_FULL : S_PARTIAL;
            end else begin
               ovf_set = 1'b1;
            end
         end
         2'b01: begin
            if (state != S_EMPTY) begin
               dout_load = 1'b1;
               valid_nxt = 1'b1;
               cnt_nxt   = cnt_dec;
               state_nxt = (cnt == CNT_ONE) ? S_EMPTY : S_PARTIAL;
            end else begin
               udf_set = 1'b1;
            end
         end
         2'b11: begin
            dout_load = 1'b1;
            valid_nxt = 1'b1;
            if (state != S_EMPTY) begin
               mem_we    = 1'b1;
               mem_waddr = rd_idx;
            end else begin
               dout_nxt = din;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_EMPTY;
         cnt           <= '0;
         dout          <= '0;
         dout_valid    <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         dout_valid <= valid_nxt;
         if (dout_load) dout <= dout_nxt;
         if (ovf_set) err_overflow <= 1'b1;
         if (udf_set) err_underflow <= 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; contents are meaningless while cnt is 0.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= din;
   end

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus randomized traffic
// compared against a queue-based stack model.
module tb_lifo_stack;

   logic       clk = 1'b0;
   logic       reset;
   logic       push, pop;
   logic [7:0] din;
   logic [7:0] dout;
   logic       dout_valid;
   logic [3:0] cnt;
   logic       empty, full, err_overflow, err_underflow;

   int checks = 0;
   int passed = 0;

   // Reference model: a queue whose back is the top of the stack.
   logic [7:0] mq[$];
   logic [7:0] m_dout;
   logic       m_valid, m_ovf, m_udf;

   lifo_stack #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
      .dout(dout), .dout_valid(dout_valid), .cnt(cnt), .empty(empty), .full(full),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic model_reset();
      mq.delete();
      m_dout  = 8'h00;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
   endtask

   task automatic model_step(input logic p, input logic q, input logic [7:0] d);
      m_valid = 1'b0;
      if (p && q) begin
         m_valid = 1'b1;
         if (mq.size() == 0) m_dout = d;
         else begin
            m_dout = mq[mq.size()-1];
            mq[mq.size()-1] = d;
         end
      end else if (p) begin
         if (mq.size() == 8) m_ovf = 1'b1;
         else mq.push_back(d);
      end else if (q) begin
         if (mq.size() == 0) m_udf = 1'b1;
         else begin
            m_dout  = mq.pop_back();
            m_valid = 1'b1;
         end
      end
   endtask

   // Drive one operation at a falling edge; return at the next falling edge for sampling.
   task automatic cycle(input logic p, input logic q, input logic [7:0] d);
      push = p;
      pop  = q;
      din  = d;
      @(posedge clk);
      model_step(p, q, d);
      @(negedge clk);
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
      din   = 8'h00;
      model_reset();
      #10;
      reset = 1'b0;
      #1;
      checks++;
      if ({cnt, empty, full, dout_valid, err_overflow, err_underflow, dout} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00})
         $display("FAIL reset_state: got cnt=%0d empty=%b full=%b valid=%b ovf=%b udf=%b dout=%h want 0 1 0 0 0 0 00",
                  cnt, empty, full, dout_valid, err_overflow, err_underflow, dout);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_lifo_order();
      logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, vals[i]);
      checks++;
      if (cnt !== 4'd3) $display("FAIL order_cnt3: got %0d want 3", cnt); else passed++;
      for (int i = 2; i >= 0; i--) begin
         cycle(1'b0, 1'b1, 8'h00);
         checks++;
         if ({dout_valid, dout, cnt} !== {1'b1, vals[i], 4'(i)})
            $display("FAIL order_pop%0d: got valid=%b dout=%h cnt=%0d want 1 %h %0d", i, dout_valid, dout, cnt, vals[i], i);
         else passed++;
      end
      cycle(1'b0, 1'b0, 8'h00);
      checks++;
      if ({dout_valid, empty, dout} !== {1'b0, 1'b1, 8'h11})
         $display("FAIL order_idle: got valid=%b empty=%b dout=%h want 0 1 11", dout_valid, empty, dout);
      else passed++;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i));
      checks++;
      if ({full, empty, cnt, err_overflow} !== {1'b1, 1'b0, 4'd8, 1'b0})
         $display("FAIL ovf_full: got full=%b empty=%b cnt=%0d ovf=%b want 1 0 8 0", full, empty, cnt, err_overflow);
      else passed++;
      cycle(1'b1, 1'b0, 8'hFF);
      checks++;
      if ({err_overflow, cnt, full} !== {1'b1, 4'd8, 1'b1})
         $display("FAIL ovf_flag: got ovf=%b cnt=%0d full=%b want 1 8 1", err_overflow, cnt, full);
      else passed++;
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if ({dout, dout_valid, cnt, full, err_overflow} !== {8'hA7, 1'b1, 4'd7, 1'b0, 1'b1})
         $display("FAIL ovf_pop: got dout=%h valid=%b cnt=%0d full=%b ovf=%b want a7 1 7 0 1",
                  dout, dout_valid, cnt, full, err_overflow);
      else passed++;
   endtask

   task automatic test_underflow();
      apply_reset();
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if ({err_underflow, dout_valid, cnt, empty} !== {1'b1, 1'b0, 4'd0, 1'b1})
         $display("FAIL udf_flag: got udf=%b valid=%b cnt=%0d empty=%b want 1 0 0 1", err_underflow, dout_valid, cnt, empty);
      else passed++;
      cycle(1'b1, 1'b0, 8'h5A);
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if ({dout, dout_valid, err_underflow, cnt} !== {8'h5A, 1'b1, 1'b1, 4'd0})
         $display("FAIL udf_recover: got dout=%h valid=%b udf=%b cnt=%0d want 5a 1 1 0", dout, dout_valid, err_underflow, cnt);
      else passed++;
   endtask

   task automatic test_push_pop_same();
      apply_reset();
      cycle(1'b1, 1'b0, 8'h01);
      cycle(1'b1, 1'b0, 8'h02);
      cycle(1'b1, 1'b1, 8'h03);
      checks++;
      if ({dout, dout_valid, cnt} !== {8'h02, 1'b1, 4'd2})
         $display("FAIL swap_top: got dout=%h valid=%b cnt=%0d want 02 1 2", dout, dout_valid, cnt);
      else passed++;
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if ({dout, cnt} !== {8'h03, 4'd1}) $display("FAIL swap_pop: got dout=%h cnt=%0d want 03 1", dout, cnt);
      else passed++;
      cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b1, 1'b1, 8'h77);
      checks++;
      if ({dout, dout_valid, cnt, empty, err_overflow, err_underflow} !== {8'h77, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0})
         $display("FAIL passthru: got dout=%h valid=%b cnt=%0d empty=%b ovf=%b udf=%b want 77 1 0 1 0 0",
                  dout, dout_valid, cnt, empty, err_overflow, err_underflow);
      else passed++;
      // Simultaneous push/pop while full must not raise overflow.
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i));
      cycle(1'b1, 1'b1, 8'hEE);
      checks++;
      if ({dout, cnt, full, err_overflow} !== {8'hC7, 4'd8, 1'b1, 1'b0})
         $display("FAIL swap_full: got dout=%h cnt=%0d full=%b ovf=%b want c7 8 1 0", dout, cnt, full, err_overflow);
      else passed++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h40 + 8'(i));
      cycle(1'b0, 1'b1, 8'h00);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({cnt, empty, full, dout, dout_valid} !== {4'd0, 1'b1, 1'b0, 8'h00, 1'b0})
         $display("FAIL async_reset: got cnt=%0d empty=%b full=%b dout=%h valid=%b want 0 1 0 00 0",
                  cnt, empty, full, dout, dout_valid);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if ({err_underflow, dout_valid, cnt} !== {1'b1, 1'b0, 4'd0})
         $display("FAIL async_udf: got udf=%b valid=%b cnt=%0d want 1 0 0", err_underflow, dout_valid, cnt);
      else passed++;
   endtask

   task automatic test_random();
      logic       p, q;
      logic [7:0] d;
      int         bias;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         if (i == 200) apply_reset();
         bias = ((i / 50) % 2 == 0) ? 70 : 30;
         p = ($urandom_range(0, 99) < bias);
         q = ($urandom_range(0, 99) < (100 - bias));
         d = 8'($urandom);
         cycle(p, q, d);
         checks++;
         if ({dout, dout_valid, cnt, empty, full, err_overflow, err_underflow} !==
             {m_dout, m_valid, 4'(mq.size()), mq.size() == 0, mq.size() == 8, m_ovf, m_udf})
            $display("FAIL random_%0d: got dout=%h v=%b cnt=%0d e=%b f=%b ovf=%b udf=%b want %h %b %0d %b %b %b %b",
                     i, dout, dout_valid, cnt, empty, full, err_overflow, err_underflow,
                     m_dout, m_valid, mq.size(), mq.size() == 0, mq.size() == 8, m_ovf, m_udf);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_lifo_order();
      test_overflow();
      test_underflow();
      test_push_pop_same();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
